// File: rtl/lut_neuron_pkg.sv
// Shared types for the runtime-loadable LUT neuron array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lut_neuron_pkg;

  // Control FSM of the array: stream evaluation, output drain, table load.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_e;

  // Width of the accepted-write counter on the config port.
  localparam int CFG_CNT_W = 16;

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron truth table: 2**IN_BITS entries of OUT_BITS, sync write, async read.
// Latency: read is combinational; a write is visible the cycle after its edge.
// Backpressure: none; the owner gates wr_en.
// Ports: clk/rst_n, wr_en/wr_addr/wr_data write port, rd_addr -> rd_data read port.
module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IN_BITS-1:0]  wr_addr,
  input  logic [OUT_BITS-1:0] wr_data,
  input  logic [IN_BITS-1:0]  rd_addr,
  output logic [OUT_BITS-1:0] rd_data
);

  localparam int DEPTH = 1 << IN_BITS;

  logic [DEPTH-1:0][OUT_BITS-1:0] mem_q;
  logic [DEPTH-1:0][OUT_BITS-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Tables clear on reset so a reset mid-load never leaves a half-written table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lut_neuron_array.sv
// Array of N_NEURONS runtime-loadable truth tables evaluated in parallel on a stream.
// Latency: one registered stage; output appears the cycle after input acceptance.
// Backpressure: in_ready = RUN && (!out_valid || out_ready); output held while stalled.
// Ports: in_* input stream, out_* output stream, cfg_* table-load handshake
//        (cfg_start enters load via drain, cfg_done leaves, cfg_err flags bad neuron id).
module lut_neuron_array
  import lut_neuron_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 6,
  parameter int OUT_BITS  = 1,
  parameter int NID_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_start,
  output logic                          cfg_ready,
  input  logic                          cfg_we,
  input  logic [NID_W-1:0]              cfg_nid,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_wdata,
  input  logic                          cfg_done,
  output logic                          cfg_err,
  output logic [CFG_CNT_W-1:0]          cfg_count
);

  // N_NEURONS always fits in NID_W+1 bits, so this compare never truncates.
  localparam logic [NID_W:0]         NID_LIM = (NID_W+1)'(N_NEURONS);
  localparam logic [CFG_CNT_W-1:0]   CNT_ONE = CFG_CNT_W'(1);

  state_e                        state_q, state_d;
  logic                          out_valid_q, out_valid_d;
  logic [N_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic                          cfg_err_q, cfg_err_d;
  logic [CFG_CNT_W-1:0]          cfg_count_q, cfg_count_d;

  logic [N_NEURONS*OUT_BITS-1:0] lookup;
  logic [N_NEURONS-1:0]          tbl_we;
  logic                          accept;
  logic                          cfg_wr;
  logic                          nid_ok;

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign nid_ok   = ({1'b0, cfg_nid} < NID_LIM);
  assign cfg_wr   = (state_q == LOAD) && cfg_we;

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    assign tbl_we[k] = cfg_wr && (cfg_nid == NID_W'(k));

    lut_neuron_table #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tbl_we[k]),
      .wr_addr (cfg_addr),
      .wr_data (cfg_wdata),
      .rd_addr (in_data[k*IN_BITS +: IN_BITS]),
      .rd_data (lookup[k*OUT_BITS +: OUT_BITS])
    );
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cfg_err_d   = 1'b0;
    cfg_count_d = cfg_count_q;

    // Output register: load on accept, otherwise retire on downstream handshake.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      RUN: begin
        if (cfg_start) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Enter LOAD as soon as the output register will be empty next cycle.
        if (!out_valid_d) begin
          state_d     = LOAD;
          cfg_count_d = '0;
        end
      end
      LOAD: begin
        if (cfg_we) begin
          if (nid_ok) begin
            if (cfg_count_q != '1) begin
              cfg_count_d = cfg_count_q + CNT_ONE;
            end
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (cfg_done) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      cfg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      cfg_count_q <= cfg_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_ready = (state_q == LOAD);
  assign cfg_err   = cfg_err_q;
  assign cfg_count = cfg_count_q;

endmodule

// File: doc/lut_neuron_array.md
Name: lut_neuron_array

Overview:
- Parametrised successor to the single fixed-table LogicNets neuron.
- Holds N_NEURONS independent truth tables, each IN_BITS in and OUT_BITS out. Tables are runtime-loadable through a config port instead of hard-coded.
- Evaluates all neurons in parallel on a valid/ready stream with one registered stage.
- Sits between quantised activation layers in the latency-optimised pipeline. It allows table updates without resynthesis.

Parameters:
- N_NEURONS, 4: number of neurons (tables) in the array.
- IN_BITS, 6: address width per neuron; each table depth is 2**IN_BITS.
- OUT_BITS, 1: output width per neuron.
- NID_W, $clog2(N_NEURONS) (min 1): neuron-select width on the config port.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  N_NEURONS*IN_BITS  neuron k address = in_data[k*IN_BITS +: IN_BITS]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream ready
- out_data  out  N_NEURONS*OUT_BITS  neuron k result = out_data[k*OUT_BITS +: OUT_BITS]
- cfg_start  in  1  request entry to table-load mode
- cfg_ready  out  1  high in LOAD state; writes accepted only then
- cfg_we  in  1  table write strobe
- cfg_nid  in  NID_W  target neuron
- cfg_addr  in  IN_BITS  table entry index
- cfg_wdata  in  OUT_BITS  entry value
- cfg_done  in  1  leave load mode
- cfg_err  out  1  one-cycle pulse: write to cfg_nid >= N_NEURONS
- cfg_count  out  16  accepted writes since last LOAD entry, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): state=RUN; out_valid=0; out_data=0; cfg_err=0; cfg_count=0; all table entries=0.
- Table semantics: entry index = unsigned address value; neuron k output = table_k[addr_k].
- States: RUN, DRAIN, LOAD.
- RUN:
  - in_ready = !out_valid || out_ready.
  - On an accepted input, out_data <= lookups of all neurons and out_valid <= 1 on the next edge. Latency is exactly 1 cycle.
  - If out_valid && out_ready with no input accepted, out_valid <= 0.
  - out_data holds stable while out_valid && !out_ready.
- RUN -> DRAIN on cfg_start. in_ready=0 from the cycle after cfg_start is sampled. An input handshaking in the same cycle as cfg_start is still accepted and produces output.
- DRAIN:
  - in_ready=0.
  - Goes to LOAD on the first cycle with out_valid=0, either already empty or after the final out_ready handshake.
  - A direct RUN->LOAD transition is not allowed; DRAIN lasts at least one cycle.
- LOAD:
  - cfg_ready=1; in_ready=0; cfg_count cleared on entry.
  - cfg_we && cfg_nid < N_NEURONS: table_nid[cfg_addr] <= cfg_wdata at the edge; cfg_count++ (saturating).
  - cfg_we && cfg_nid >= N_NEURONS: no write; cfg_err=1 on the next cycle only.
- LOAD -> RUN on cfg_done. A cfg_we in the same cycle as cfg_done is performed. The first RUN-cycle lookup sees the new contents.
- cfg_we outside LOAD: ignored, no error. cfg_start in DRAIN/LOAD and cfg_done outside LOAD: ignored.
- Repeated writes to the same entry: the last write wins.
- Reset mid-LOAD or mid-DRAIN: tables return to 0 and in-flight output is discarded (out_valid=0).
- No combinational path from out_ready to out_data; in_ready may depend combinationally on out_ready.

Decomposition:
- Package lut_neuron_pkg: state enum (RUN, DRAIN, LOAD) and the cfg_count width constant.
- Sub-module lut_neuron_table (one per neuron, generate loop):
  - Holds 2**IN_BITS x OUT_BITS distributed-style registers with a sync write port and an async read port.
  - The array top owns the FSM, output register and counters.

Test Plan (N_NEURONS=2, IN_BITS=6, OUT_BITS=1):
- After reset, in_data=12'h0C8 with out_ready=1 -> out_valid=1 one cycle later, out_data=2'b00; cfg_count=0.
- cfg_start, then in LOAD write (nid0, addr 6'h08, 1) and (nid1, addr 6'h03, 1), then cfg_done. Then input {6'h03, 6'h08} -> out_data=2'b11 one cycle later; cfg_count=2.
- Output stalled (out_valid=1, out_ready=0) with cfg_start pulsed -> state stays DRAIN, cfg_ready=0, out_data held. Raise out_ready -> handshake, then cfg_ready=1 the following cycle.
- In LOAD, cfg_we with cfg_nid=1'b1 at N_NEURONS=2 succeeds. Rerun the case with N_NEURONS=3, cfg_nid=2'd3 -> cfg_err high exactly one cycle; tables and cfg_count unchanged.
- Back-to-back inputs 6'h08, 6'h09, 6'h0A to neuron 0 with out_ready toggling 1,0,1 -> three outputs in order, none lost or duplicated.
- Assert rst_n low mid-LOAD after 5 writes -> out_valid=0, cfg_count=0, and all lookups return 0 after release.
